hwpe_vfpu_job_ctrl: RTL and testbench

Job sequencer for the vector-FPU HWPE: on a start trigger from the control register file it latches the job configuration (three base addresses, transaction size, operation, rounding mode), validates it, issues one request to each of the two source streamers (A, B) and the result sink streamer, and holds the VFPU control word stable. It then counts result beats and completes when all beats are seen and the sink reports completion. It sits between the register file/controller slave and the streamers plus VFPU datapath.

---
 rtl/hwpe_vfpu_job_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hwpe_vfpu_job_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hwpe_vfpu_job_ctrl.sv
// Job sequencer for the vector-FPU HWPE: latches a job, validates it, issues
// the three streamer requests, counts result beats and signals completion.
module hwpe_vfpu_job_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16,
  parameter int NUM_OPS    = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_b_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_res_i,
  input  logic [SIZE_WIDTH-1:0] trans_size_i,
  input  logic [2:0]            operation_i,
  input  logic [1:0]            rounding_mode_i,
  output logic                  a_req_valid_o,
  output logic                  b_req_valid_o,
  output logic                  res_req_valid_o,
  input  logic                  a_req_ready_i,
  input  logic                  b_req_ready_i,
  input  logic                  res_req_ready_i,
  output logic [ADDR_WIDTH-1:0] addr_a_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  output logic [ADDR_WIDTH-1:0] addr_res_o,
  output logic [SIZE_WIDTH-1:0] len_o,
  output logic [4:0]            vfpu_ctrl_o,
  input  logic                  res_beat_i,
  input  logic                  sink_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [SIZE_WIDTH-1:0] res_cnt_o
);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, RUN, DRAIN, DONE} state_e;

  localparam logic [3:0] NumOpsL = 4'(NUM_OPS);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q, addr_res_q;
  logic [SIZE_WIDTH-1:0] len_q;
  logic [2:0]            op_q;
  logic [1:0]            rm_q;
  logic                  err_q, err_d;
  logic [SIZE_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                  a_acc_q, a_acc_d, b_acc_q, b_acc_d, r_acc_q, r_acc_d;
  logic                  sdone_q, sdone_d;
  logic                  latch_cfg;

  assign cnt_inc = cnt_q + SIZE_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    a_acc_d   = a_acc_q;
    b_acc_d   = b_acc_q;
    r_acc_d   = r_acc_q;
    sdone_d   = sdone_q;
    latch_cfg = 1'b0;

    if (sink_done_i && (state_q == REQ || state_q == RUN || state_q == DRAIN))
      sdone_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          latch_cfg = 1'b1;
          cnt_d     = '0;
          a_acc_d   = 1'b0;
          b_acc_d   = 1'b0;
          r_acc_d   = 1'b0;
          sdone_d   = 1'b0;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if ({1'b0, op_q} >= NumOpsL) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          err_d   = 1'b0;
          state_d = (len_q == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        a_acc_d = a_acc_q | (a_req_valid_o & a_req_ready_i);
        b_acc_d = b_acc_q | (b_req_valid_o & b_req_ready_i);
        r_acc_d = r_acc_q | (res_req_valid_o & res_req_ready_i);
        if (a_acc_d && b_acc_d && r_acc_d) state_d = RUN;
      end
      RUN: begin
        // Counter saturates at len; reaching it moves on to wait for the sink.
        if (res_beat_i && cnt_q != len_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (sdone_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Soft clear aborts the job but keeps the latched config and error flag.
    if (clear_i) begin
      state_d   = IDLE;
      cnt_d     = '0;
      a_acc_d   = 1'b0;
      b_acc_d   = 1'b0;
      r_acc_d   = 1'b0;
      sdone_d   = 1'b0;
      latch_cfg = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      a_acc_q <= 1'b0;
      b_acc_q <= 1'b0;
      r_acc_q <= 1'b0;
      sdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      a_acc_q <= a_acc_d;
      b_acc_q <= b_acc_d;
      r_acc_q <= r_acc_d;
      sdone_q <= sdone_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_res_q <= '0;
      len_q      <= '0;
      op_q       <= '0;
      rm_q       <= '0;
    end else if (latch_cfg) begin
      addr_a_q   <= base_addr_a_i;
      addr_b_q   <= base_addr_b_i;
      addr_res_q <= base_addr_res_i;
      len_q      <= trans_size_i;
      op_q       <= operation_i;
      rm_q       <= rounding_mode_i;
    end
  end

  assign a_req_valid_o   = (state_q == REQ) && !a_acc_q;
  assign b_req_valid_o   = (state_q == REQ) && !b_acc_q;
  assign res_req_valid_o = (state_q == REQ) && !r_acc_q;
  assign addr_a_o        = addr_a_q;
  assign addr_b_o        = addr_b_q;
  assign addr_res_o      = addr_res_q;
  assign len_o           = len_q;
  assign vfpu_ctrl_o     = {op_q, rm_q};
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign err_o           = err_q;
  assign res_cnt_o       = cnt_q;

endmodule

// File: tb/tb_hwpe_vfpu_job_ctrl.sv
// Directed bench for hwpe_vfpu_job_ctrl: per-cycle vector table plus
// hand-written sequences for handshake staggering, clear and reset.
module tb_hwpe_vfpu_job_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, clear;
  logic [31:0] ba, bb, br;
  logic [15:0] sz;
  logic [2:0]  op;
  logic [1:0]  rm;
  logic        va, vb, vr, ra, rb, rr;
  logic [31:0] aa, ab, ares;
  logic [15:0] len;
  logic [4:0]  ctrl;
  logic        beat, sdone, busy, done, err;
  logic [15:0] cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hwpe_vfpu_job_ctrl #(.ADDR_WIDTH(32), .SIZE_WIDTH(16), .NUM_OPS(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .base_addr_a_i(ba), .base_addr_b_i(bb), .base_addr_res_i(br),
    .trans_size_i(sz), .operation_i(op), .rounding_mode_i(rm),
    .a_req_valid_o(va), .b_req_valid_o(vb), .res_req_valid_o(vr),
    .a_req_ready_i(ra), .b_req_ready_i(rb), .res_req_ready_i(rr),
    .addr_a_o(aa), .addr_b_o(ab), .addr_res_o(ares), .len_o(len),
    .vfpu_ctrl_o(ctrl), .res_beat_i(beat), .sink_done_i(sdone),
    .busy_o(busy), .done_o(done), .err_o(err), .res_cnt_o(cnt)
  );

  typedef struct {
    logic        st;
    logic [2:0]  op;
    logic [1:0]  rm;
    logic [15:0] sz;
    logic        bt, sd;
    logic        busy, done, err;
    logic [2:0]  v;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_row(input int i, input logic st, input logic [2:0] o, input logic [1:0] r,
                         input logic [15:0] s, input logic bt, input logic sd, input logic bu,
                         input logic dn, input logic er, input logic [2:0] v, input logic [15:0] c);
    tbl[i].st = st; tbl[i].op = o; tbl[i].rm = r; tbl[i].sz = s;
    tbl[i].bt = bt; tbl[i].sd = sd; tbl[i].busy = bu; tbl[i].done = dn;
    tbl[i].err = er; tbl[i].v = v; tbl[i].cnt = c;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
    chk({tag, " err"}, {31'd0, err}, 32'd0);
    chk({tag, " valids"}, {29'd0, va, vb, vr}, 32'd0);
    chk({tag, " cnt"}, {16'd0, cnt}, 32'd0);
    chk({tag, " addrs"}, aa | ab | ares, 32'd0);
    chk({tag, " len"}, {16'd0, len}, 32'd0);
    chk({tag, " ctrl"}, {27'd0, ctrl}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 0; clear = 0; op = 0; rm = 0; sz = 0;
    ba = 32'h1000; bb = 32'h2000; br = 32'h3000;
    ra = 1; rb = 1; rr = 1; beat = 0; sdone = 0;

    //        i  st op rm sz  bt sd busy dn er v       cnt
    set_row( 0, 1, 2, 1, 4,  0, 0, 0, 0, 0, 3'b000, 0);
    set_row( 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'b000, 0);
    set_row( 2, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'b111, 0);
    set_row( 3, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'b000, 0);
    set_row( 4, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'b000, 1);
    set_row( 5, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'b000, 2);
    set_row( 6, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'b000, 3);
    set_row( 7, 0, 0, 0, 0,  0, 1, 1, 0, 0, 3'b000, 4);
    set_row( 8, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'b000, 4);
    set_row( 9, 0, 0, 0, 0,  0, 0, 1, 1, 0, 3'b000, 4);
    set_row(10, 1, 6, 0, 4,  1, 0, 0, 0, 0, 3'b000, 4);
    set_row(11, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'b000, 0);
    set_row(12, 0, 0, 0, 0,  0, 0, 1, 1, 1, 3'b000, 0);
    set_row(13, 1, 1, 0, 0,  0, 0, 0, 0, 1, 3'b000, 0);
    set_row(14, 0, 0, 0, 0,  0, 0, 1, 0, 1, 3'b000, 0);
    set_row(15, 0, 0, 0, 0,  0, 0, 1, 1, 0, 3'b000, 0);
    set_row(16, 1, 0, 3, 2,  0, 0, 0, 0, 0, 3'b000, 0);
    set_row(17, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'b000, 0);
    set_row(18, 0, 0, 0, 0,  1, 1, 1, 0, 0, 3'b111, 0);
    set_row(19, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'b000, 0);
    set_row(20, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'b000, 1);
    set_row(21, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'b000, 2);
    set_row(22, 0, 0, 0, 0,  0, 0, 1, 1, 0, 3'b000, 2);
    set_row(23, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 2);

    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("row%0d done", i), {31'd0, done}, {31'd0, tbl[i].done});
      chk($sformatf("row%0d err", i), {31'd0, err}, {31'd0, tbl[i].err});
      chk($sformatf("row%0d valids", i), {29'd0, va, vb, vr}, {29'd0, tbl[i].v});
      chk($sformatf("row%0d cnt", i), {16'd0, cnt}, {16'd0, tbl[i].cnt});
      start = tbl[i].st; op = tbl[i].op; rm = tbl[i].rm; sz = tbl[i].sz;
      beat = tbl[i].bt; sdone = tbl[i].sd;
      if (i == 3) chk("job1 ctrl", {27'd0, ctrl}, 32'h09);
      if (i == 3) chk("job1 len", {16'd0, len}, 32'd4);
    end

    // Staggered readies: A in cycle 2, res in cycle 4, B in cycle 6.
    @(negedge clk);
    start = 1; op = 3; rm = 2; sz = 1; ra = 0; rb = 0; rr = 0; beat = 0; sdone = 0;
    @(negedge clk); start = 0; op = 0; rm = 0; sz = 0;
    chk("stg c1 busy", {31'd0, busy}, 32'd1);
    @(negedge clk); chk("stg c2 valids", {29'd0, va, vb, vr}, 32'b111); ra = 1;
    @(negedge clk); chk("stg c3 valids", {29'd0, va, vb, vr}, 32'b011); ra = 0;
    @(negedge clk); chk("stg c4 valids", {29'd0, va, vb, vr}, 32'b011); rr = 1;
    @(negedge clk); chk("stg c5 valids", {29'd0, va, vb, vr}, 32'b010); rr = 0;
    @(negedge clk); chk("stg c6 valids", {29'd0, va, vb, vr}, 32'b010); rb = 1;
    @(negedge clk); rb = 0;
    chk("stg c7 valids", {29'd0, va, vb, vr}, 32'b000);
    chk("stg c7 busy", {31'd0, busy}, 32'd1);
    chk("stg ctrl", {27'd0, ctrl}, 32'h0E);
    chk("stg len", {16'd0, len}, 32'd1);
    chk("stg addrs", {aa[15:0], ab[15:8], ares[15:8]}, 32'h1000_2030);
    beat = 1; sdone = 1;
    @(negedge clk); beat = 0; sdone = 0;
    chk("stg c8 cnt", {16'd0, cnt}, 32'd1);
    chk("stg c8 done", {31'd0, done}, 32'd0);
    @(negedge clk); chk("stg c9 done", {31'd0, done}, 32'd1);
    @(negedge clk); chk("stg c10 busy", {31'd0, busy}, 32'd0);

    // Clear in RUN at count 2 together with start.
    start = 1; op = 2; rm = 1; sz = 4; ra = 1; rb = 1; rr = 1;
    @(negedge clk); start = 0; op = 0; rm = 0; sz = 0;
    @(negedge clk);
    @(negedge clk); beat = 1;
    @(negedge clk);
    @(negedge clk); chk("clr cnt before", {16'd0, cnt}, 32'd2);
    clear = 1; start = 1; op = 7; sz = 9;
    @(negedge clk); clear = 0; start = 0; op = 0; sz = 0; beat = 0;
    chk("clr busy", {31'd0, busy}, 32'd0);
    chk("clr cnt", {16'd0, cnt}, 32'd0);
    chk("clr done", {31'd0, done}, 32'd0);
    chk("clr ctrl kept", {27'd0, ctrl}, 32'h09);
    chk("clr len kept", {16'd0, len}, 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("clr idle%0d", k), {30'd0, busy, done}, 32'd0);
    end

    // Start while busy is ignored.
    start = 1; op = 1; rm = 0; sz = 1; ra = 0; rb = 0; rr = 0;
    @(negedge clk); start = 0; op = 0; sz = 0;
    @(negedge clk); start = 1; op = 4; rm = 3; sz = 9;
    @(negedge clk); start = 0; op = 0; rm = 0; sz = 0;
    chk("busy start ctrl", {27'd0, ctrl}, 32'h04);
    chk("busy start len", {16'd0, len}, 32'd1);
    chk("busy start va", {31'd0, va}, 32'd1);
    clear = 1;
    @(negedge clk); clear = 0;
    chk("busy clr va", {31'd0, va}, 32'd0);
    chk("busy clr busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of REQ.
    start = 1; op = 2; rm = 1; sz = 4;
    @(negedge clk); start = 0; op = 0; rm = 0; sz = 0;
    @(negedge clk);
    @(negedge clk); chk("rstreq va", {31'd0, va}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_idle_zero("midrst");
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d", k), {30'd0, busy, done}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
